accum_stream_tx: RTL

- Consumer end of the accumulator output interface: captures each 48-bit accumulated result, marked by a one-cycle `valid_in` pulse, into a small FIFO.
- Transmits each result as a two-beat 32-bit AXI4-Stream packet with `tvalid`/`tready` backpressure.
- Decouples the no-backpressure accumulator pulse stream from the downstream DMA/stream fabric.
- Reports overflow when results arrive faster than the sink drains them.

---
 rtl/accum_stream_tx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/accum_stream_tx.sv
// Accumulator result FIFO + two-beat AXI4-Stream transmitter with overflow tracking.
// Optional macro ACCUM_STREAM_TX_SEQ_EN: carry a per-result sequence number in beat1's upper half.
module accum_stream_tx #(
  parameter int FIFO_AW   = 4,
  parameter int SEQ_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [47:0]        data_in,
  input  logic               clr_ovf,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               overflow,
  output logic [15:0]        drop_cnt,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int LVL_W = FIFO_AW + 1;
`ifdef ACCUM_STREAM_TX_SEQ_EN
  localparam int EW = 48 + SEQ_WIDTH;
`else
  localparam int EW = 48;
`endif

  if (SEQ_WIDTH < 1 || SEQ_WIDTH > 16) begin : g_bad_seq_width
    $error("accum_stream_tx: SEQ_WIDTH must be in 1..16");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_pop;

  logic [EW-1:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic [47:0]          r_out_data;
  logic                 r_overflow;
  logic [15:0]          r_drop_cnt;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr;
  logic                 w_drop;
  logic [EW-1:0]        w_wr_entry;
  logic [EW-1:0]        w_rd_entry;
  logic [15:0]          w_hi16;

  assign w_full     = (r_level == LVL_W'(DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_wr       = valid_in & ~w_full;
  assign w_drop     = valid_in & w_full;
  assign w_rd_entry = r_mem[r_rd_ptr];

`ifdef ACCUM_STREAM_TX_SEQ_EN
  logic [SEQ_WIDTH-1:0] r_seq;
  logic [SEQ_WIDTH-1:0] r_out_seq;

  // Sequence advances on every strobe, so dropped results show up as gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= '0;
    end else if (valid_in) begin
      r_seq <= r_seq + SEQ_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_seq <= '0;
    end else if (w_pop) begin
      r_out_seq <= w_rd_entry[EW-1:48];
    end
  end

  assign w_wr_entry = {r_seq, data_in};
  assign w_hi16     = 16'(r_out_seq);
`else
  assign w_wr_entry = data_in;
  assign w_hi16     = {16{r_out_data[47]}};
`endif

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins: the new drop is the first one counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf) begin
        r_drop_cnt <= 16'd1;
      end else if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (m_axis_tready) begin
          w_state_nxt = ST_BEAT1;
        end
      end
      ST_BEAT1: begin
        if (m_axis_tready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_BEAT0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
    end else if (w_pop) begin
      r_out_data <= w_rd_entry[47:0];
    end
  end

  // Outputs decode only registered state, so tvalid never depends on tready.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    case (r_state)
      ST_BEAT0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = r_out_data[31:0];
      end
      ST_BEAT1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = {w_hi16, r_out_data[47:32]};
      end
      default: ;
    endcase
  end

  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;
  assign fifo_level = r_level;

endmodule
